// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package pipe_adder_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int CHUNK_DEF = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int stages_f(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle between the operand registers, the adder pipe and the ALU mux.
interface pipe_adder_if
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s_out;
   logic             c_out;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, s_out, c_out, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, s_out, c_out, ovf, zero
   );

endinterface

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple slice; also exposes the carry into its top bit for overflow.
module chunk_adder
   import pipe_adder_pkg::*;
#(
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] s_out,
   output logic             c_out,
   output logic             c_msb_in
);

   logic [CHUNK:0] carry;

   assign carry[0] = c_in;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder u_fa (
         .a     (a[i]),
         .b     (b[i]),
         .c_in  (carry[i]),
         .s_out (s_out[i]),
         .c_out (carry[i+1])
      );
   end

   assign c_out    = carry[CHUNK];
   assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the building block of each ripple slice.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s_out,
   output logic c_out
);

   assign s_out = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one CHUNK-bit ripple slice per stage, carry and operands skewed
// through stage registers, single global stall driven by the result consumer.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   pipe_adder_if.slave   bus
);

   localparam int STAGES = stages_f(WIDTH, CHUNK);

   logic              advance;
   logic [STAGES-1:0] valid_q;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic              carry_q [STAGES];
   logic              ovf_q;
   logic              zero_q;

   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_in [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic              cin_d  [STAGES];
   logic              cout_d [STAGES];
   logic              cmsb_d [STAGES];
   logic [CHUNK-1:0]  slice_s [STAGES];

   // NOTE: in_ready depends only on the output side, never on in_valid, so no comb loop
   // can form through an upstream that waits for ready before raising valid.
   assign advance       = !valid_q[STAGES-1] || bus.out_ready;
   assign bus.in_ready  = advance;
   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.s_out     = sum_q[STAGES-1];
   assign bus.c_out     = carry_q[STAGES-1];
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         // Subtraction is a + ~b + ~c_in, so a borrow-in of 1 removes one more.
         assign a_d[0]    = bus.a;
         assign b_d[0]    = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
         assign cin_d[0]  = (bus.sub == OP_ADD) ? bus.c_in : ~bus.c_in;
         assign sum_in[0] = '0;
      end else begin : g_next
         assign a_d[k]    = a_q[k-1];
         assign b_d[k]    = b_q[k-1];
         assign cin_d[k]  = carry_q[k-1];
         assign sum_in[k] = sum_q[k-1];
      end

      chunk_adder #(.CHUNK(CHUNK)) u_chunk (
         .a        (a_d[k][k*CHUNK +: CHUNK]),
         .b        (b_d[k][k*CHUNK +: CHUNK]),
         .c_in     (cin_d[k]),
         .s_out    (slice_s[k]),
         .c_out    (cout_d[k]),
         .c_msb_in (cmsb_d[k])
      );

      assign sum_d[k] = sum_in[k] | (WIDTH'(slice_s[k]) << (k * CHUNK));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k]   <= '0;
            carry_q[k] <= 1'b0;
         end
      end else if (advance) begin
         valid_q[0] <= bus.in_valid;
         for (int k = 1; k < STAGES; k++) valid_q[k] <= valid_q[k-1];
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= cout_d[k];
         end
         ovf_q  <= cmsb_d[STAGES-1] ^ cout_d[STAGES-1];
         zero_q <= (sum_d[STAGES-1] == '0);
      end
   end

   // NOTE: skewed operand registers carry no reset; the stage valid bits already mark them
   // as meaningless after reset, and leaving them out keeps the reset net small.
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
         end
      end
   end

endmodule
